// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO: read-mode enum, pointer wrap and level width.
package sync_fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Wrap is explicit so non-power-of-two depths work.
   function automatic int ptr_next(input int ptr, input int size);
      return (ptr >= size - 1) ? 0 : ptr + 1;
   endfunction

   function automatic int level_width(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port, one combinational read-address port.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int BITS = 32,
   parameter int SIZE = 16,
   parameter int AW   = $clog2(SIZE)
) (
   input  logic            clk,
   input  logic            i_wr_en,
   input  logic [AW-1:0]   i_wr_addr,
   input  logic [BITS-1:0] i_wr_data,
   input  logic [AW-1:0]   i_rd_addr,
   output logic [BITS-1:0] o_rd_data
);

   logic [BITS-1:0] r_mem [SIZE];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO of any depth >= 2 with standard or first-word-fall-through read and exact level.
// Optional sticky wr_overflow/rd_underflow flags with err_clr when SYNC_FIFO_ERR_EN is defined.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int BITS       = 32,
   parameter int SIZE       = 16,
   parameter int FWFT       = 0,
   parameter int AFULL_THR  = SIZE - 2,
   parameter int AEMPTY_THR = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [BITS-1:0]              wr_data,
   output logic                         wr_full,
   output logic                         wr_almost_full,
   input  logic                         rd_en,
   output logic [BITS-1:0]              rd_data,
   output logic                         rd_empty,
   output logic                         rd_almost_empty,
   output logic [level_width(SIZE)-1:0] level
`ifdef SYNC_FIFO_ERR_EN
   ,
   input  logic                         err_clr,
   output logic                         wr_overflow,
   output logic                         rd_underflow
`endif
);

   localparam int         PTR_W = $clog2(SIZE);
   localparam int         LVL_W = level_width(SIZE);
   localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   if (SIZE < 2) begin : g_bad_size
      $error("sync_fifo: SIZE must be >= 2");
   end
   if (AFULL_THR < 1 || AFULL_THR > SIZE) begin : g_bad_afull
      $error("sync_fifo: AFULL_THR must be in 1..SIZE");
   end
   if (AEMPTY_THR < 0 || AEMPTY_THR > SIZE - 1) begin : g_bad_aempty
      $error("sync_fifo: AEMPTY_THR must be in 0..SIZE-1");
   end
   if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("sync_fifo: FWFT must be 0 or 1");
   end

   // Handshake: a write is taken when wr_en && !wr_full and a read when rd_en && !rd_empty, both
   // sampled at posedge clk; full/empty come from the registered level, so there is no bypass and a
   // refused request leaves every register untouched.
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [PTR_W-1:0] w_wr_ptr_nxt;
   logic [PTR_W-1:0] w_rd_ptr_nxt;
   logic             w_wr_acc;
   logic             w_rd_acc;
   logic [BITS-1:0]  w_mem_rd_data;

   assign wr_full         = (r_level == LVL_W'(SIZE));
   assign wr_almost_full  = (r_level >= LVL_W'(AFULL_THR));
   assign rd_empty        = (r_level == '0);
   assign rd_almost_empty = (r_level <= LVL_W'(AEMPTY_THR));
   assign level           = r_level;

   assign w_wr_acc     = wr_en && !wr_full;
   assign w_rd_acc     = rd_en && !rd_empty;
   assign w_wr_ptr_nxt = PTR_W'(ptr_next(int'(r_wr_ptr), SIZE));
   assign w_rd_ptr_nxt = PTR_W'(ptr_next(int'(r_rd_ptr), SIZE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= w_wr_ptr_nxt;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= w_rd_ptr_nxt;
         end
         if (w_wr_acc && !w_rd_acc) begin
            r_level <= r_level + LVL_W'(1);
         end else if (w_rd_acc && !w_wr_acc) begin
            r_level <= r_level - LVL_W'(1);
         end
      end
   end

   sync_fifo_mem #(
      .BITS (BITS),
      .SIZE (SIZE),
      .AW   (PTR_W)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (wr_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_mem_rd_data)
   );

   if (MODE == FIFO_FWFT) begin : g_fwft
      assign rd_data = w_mem_rd_data;
   end else begin : g_std
      logic [BITS-1:0] r_rd_data;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_rd_data <= '0;
         end else if (w_rd_acc) begin
            r_rd_data <= w_mem_rd_data;
         end
      end

      assign rd_data = r_rd_data;
   end

`ifdef SYNC_FIFO_ERR_EN
   logic r_wr_overflow;
   logic r_rd_underflow;

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_overflow  <= 1'b0;
         r_rd_underflow <= 1'b0;
      end else begin
         if (wr_en && wr_full) begin
            r_wr_overflow <= 1'b1;
         end else if (err_clr) begin
            r_wr_overflow <= 1'b0;
         end
         if (rd_en && rd_empty) begin
            r_rd_underflow <= 1'b1;
         end else if (err_clr) begin
            r_rd_underflow <= 1'b0;
         end
      end
   end

   assign wr_overflow  = r_wr_overflow;
   assign rd_underflow = r_rd_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a SIZE=5 standard-read build and a SIZE=16 FWFT build share one stimulus
// stream and are compared every cycle against queue-based reference models.
module tb_sync_fifo;

   localparam int W        = 32;
   localparam int A_SIZE   = 5;
   localparam int A_AFULL  = 3;
   localparam int A_AEMPTY = 2;
   localparam int B_SIZE   = 16;
   localparam int B_AFULL  = 14;
   localparam int B_AEMPTY = 2;

   // clock / reset / shared inputs
   logic         clk = 1'b0;
   logic         rst_n;
   logic         wr_en;
   logic         rd_en;
   logic [W-1:0] wr_data;

   always #5 clk = ~clk;

   logic         full_a, afull_a, empty_a, aempty_a;
   logic [W-1:0] rd_data_a;
   logic [2:0]   level_a;
   logic         full_b, afull_b, empty_b, aempty_b;
   logic [W-1:0] rd_data_b;
   logic [4:0]   level_b;
`ifdef SYNC_FIFO_ERR_EN
   logic         err_clr;
   logic         ov_a, un_a, ov_b, un_b;
`endif

   sync_fifo #(
      .BITS(W), .SIZE(A_SIZE), .FWFT(0), .AFULL_THR(A_AFULL), .AEMPTY_THR(A_AEMPTY)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .wr_full(full_a), .wr_almost_full(afull_a),
      .rd_en(rd_en), .rd_data(rd_data_a), .rd_empty(empty_a), .rd_almost_empty(aempty_a),
      .level(level_a)
`ifdef SYNC_FIFO_ERR_EN
      , .err_clr(err_clr), .wr_overflow(ov_a), .rd_underflow(un_a)
`endif
   );

   sync_fifo #(
      .BITS(W), .SIZE(B_SIZE), .FWFT(1), .AFULL_THR(B_AFULL), .AEMPTY_THR(B_AEMPTY)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .wr_full(full_b), .wr_almost_full(afull_b),
      .rd_en(rd_en), .rd_data(rd_data_b), .rd_empty(empty_b), .rd_almost_empty(aempty_b),
      .level(level_b)
`ifdef SYNC_FIFO_ERR_EN
      , .err_clr(err_clr), .wr_overflow(ov_b), .rd_underflow(un_b)
`endif
   );

   // scoreboard state
   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] exp_q_a[$];
   logic [W-1:0] exp_q_b[$];
   logic [W-1:0] exp_rd_a = '0;
   logic [W-1:0] dummy;
`ifdef SYNC_FIFO_ERR_EN
   bit exp_ov_a = 0, exp_un_a = 0, exp_ov_b = 0, exp_un_b = 0;
`endif

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: applies the inputs present at the coming clock edge.
   task automatic model_edge();
      bit acc_wa, acc_ra, acc_wb, acc_rb;
      if (!rst_n) begin
         exp_q_a.delete();
         exp_q_b.delete();
         exp_rd_a = '0;
`ifdef SYNC_FIFO_ERR_EN
         exp_ov_a = 0; exp_un_a = 0; exp_ov_b = 0; exp_un_b = 0;
`endif
      end else begin
         acc_wa = wr_en && (exp_q_a.size() < A_SIZE);
         acc_ra = rd_en && (exp_q_a.size() > 0);
         acc_wb = wr_en && (exp_q_b.size() < B_SIZE);
         acc_rb = rd_en && (exp_q_b.size() > 0);
`ifdef SYNC_FIFO_ERR_EN
         if (wr_en && exp_q_a.size() == A_SIZE) exp_ov_a = 1; else if (err_clr) exp_ov_a = 0;
         if (rd_en && exp_q_a.size() == 0)      exp_un_a = 1; else if (err_clr) exp_un_a = 0;
         if (wr_en && exp_q_b.size() == B_SIZE) exp_ov_b = 1; else if (err_clr) exp_ov_b = 0;
         if (rd_en && exp_q_b.size() == 0)      exp_un_b = 1; else if (err_clr) exp_un_b = 0;
`endif
         if (acc_ra) exp_rd_a = exp_q_a.pop_front();
         if (acc_wa) exp_q_a.push_back(wr_data);
         if (acc_rb) dummy = exp_q_b.pop_front();
         if (acc_wb) exp_q_b.push_back(wr_data);
      end
   endtask

   task automatic check_outputs();
      int la, lb;
      la = exp_q_a.size();
      lb = exp_q_b.size();
      check("a.level",  W'(level_a),  W'(la));
      check("a.full",   W'(full_a),   W'(la == A_SIZE));
      check("a.afull",  W'(afull_a),  W'(la >= A_AFULL));
      check("a.empty",  W'(empty_a),  W'(la == 0));
      check("a.aempty", W'(aempty_a), W'(la <= A_AEMPTY));
      check("a.rdata",  rd_data_a,    exp_rd_a);
      check("b.level",  W'(level_b),  W'(lb));
      check("b.full",   W'(full_b),   W'(lb == B_SIZE));
      check("b.afull",  W'(afull_b),  W'(lb >= B_AFULL));
      check("b.empty",  W'(empty_b),  W'(lb == 0));
      check("b.aempty", W'(aempty_b), W'(lb <= B_AEMPTY));
      if (lb > 0) check("b.head", rd_data_b, exp_q_b[0]);
`ifdef SYNC_FIFO_ERR_EN
      check("a.ovf", W'(ov_a), W'(exp_ov_a));
      check("a.unf", W'(un_a), W'(exp_un_a));
      check("b.ovf", W'(ov_b), W'(exp_ov_b));
      check("b.unf", W'(un_b), W'(exp_un_b));
`endif
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   // driver tasks
   task automatic drive(input bit w, input bit r, input logic [W-1:0] d);
      wr_en   = w;
      rd_en   = r;
      wr_data = d;
      cycle();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
   endtask

`ifdef SYNC_FIFO_ERR_EN
   task automatic drive_clr(input bit w, input bit r, input logic [W-1:0] d);
      err_clr = 1'b1;
      drive(w, r, d);
      err_clr = 1'b0;
   endtask
`endif

   initial begin
      int p_wr, p_rd;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
`ifdef SYNC_FIFO_ERR_EN
      err_clr = 1'b0;
`endif
      repeat (2) cycle();
      rst_n = 1'b1;
      check("rst.level",  W'(level_a),  0);
      check("rst.empty",  W'(empty_a),  1);
      check("rst.aempty", W'(aempty_a), 1);
      check("rst.full",   W'(full_a),   0);
      check("rst.afull",  W'(afull_a),  0);
      check("rst.rdata",  rd_data_a,    0);

      // fill to full, then one rejected write
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 32'hA0 + i);
         check("t1.level", W'(level_a), i + 1);
         check("t1.afull", W'(afull_a), W'((i + 1) >= 3));
      end
      check("t1.full", W'(full_a), 1);
      drive(1, 0, 32'hEE);
      check("t1.rejected", W'(level_a), 5);

      // drain in order, then one rejected read
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, '0);
         check("t2.data", rd_data_a, 32'hA0 + i);
      end
      check("t2.empty", W'(empty_a), 1);
      drive(0, 1, '0);
      check("t2.rejected", W'(level_a), 0);
      check("t2.hold", rd_data_a, 32'hA4);
      drive(0, 1, '0);

      // wrap-around through the pointer limit
      for (int i = 0; i < 13; i++) begin
         drive(1, 0, W'(i));
         check("t3.b_head", rd_data_b, W'(i));
         drive(0, 1, '0);
         check("t3.a_data", rd_data_a, W'(i));
      end

      // simultaneous write and read at level 2, full and empty
      drive(1, 0, 32'd1);
      drive(1, 0, 32'd2);
      drive(1, 1, 32'd3);
      check("t4.mid_level", W'(level_a), 2);
      check("t4.mid_data", rd_data_a, 32'd1);
      drive(1, 0, 32'd4);
      drive(1, 0, 32'd5);
      drive(1, 0, 32'd6);
      check("t4.full", W'(full_a), 1);
      drive(1, 1, 32'd7);
      check("t4.full_level", W'(level_a), 4);
      check("t4.full_data", rd_data_a, 32'd2);
      repeat (4) drive(0, 1, '0);
      check("t4.drained", rd_data_a, 32'd6);
      drive(1, 1, 32'd8);
      check("t4.empty_level", W'(level_a), 1);
      check("t4.empty_hold", rd_data_a, 32'd6);
      drive(0, 1, '0);
      check("t4.empty_data", rd_data_a, 32'd8);

      // reset mid-stream discards contents
      drive(1, 0, 32'h31);
      drive(1, 0, 32'h32);
      drive(0, 1, '0);
      drive(1, 0, 32'h33);
      drive(1, 0, 32'h34);
      check("t5.level", W'(level_a), 3);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("t5.level0", W'(level_a), 0);
      check("t5.empty", W'(empty_a), 1);
      check("t5.rdata", rd_data_a, 0);
      check("t5.b_level0", W'(level_b), 0);
      drive(1, 0, 32'h55);
      check("t5.b_head", rd_data_b, 32'h55);
      drive(0, 1, '0);
      check("t5.a_data", rd_data_a, 32'h55);

`ifdef SYNC_FIFO_ERR_EN
      // sticky error flags
      for (int i = 0; i < 5; i++) drive(1, 0, 32'hC0 + i);
      check("t6.ovf_pre", W'(ov_a), 0);
      drive(1, 0, 32'hCF);
      check("t6.ovf_set", W'(ov_a), 1);
      drive(0, 0, '0);
      check("t6.ovf_hold", W'(ov_a), 1);
      drive_clr(1, 0, 32'hCE);
      check("t6.ovf_setwins", W'(ov_a), 1);
      drive_clr(0, 0, '0);
      check("t6.ovf_clr", W'(ov_a), 0);
      repeat (5) drive(0, 1, '0);
      check("t6.unf_pre", W'(un_a), 0);
      drive(0, 1, '0);
      check("t6.unf_set", W'(un_a), 1);
      drive(0, 0, '0);
      check("t6.unf_hold", W'(un_a), 1);
      drive_clr(0, 1, '0);
      check("t6.unf_setwins", W'(un_a), 1);
      drive_clr(0, 0, '0);
      check("t6.unf_clr", W'(un_a), 0);
`endif

      // randomized traffic with shifting write/read bias and rare resets
      p_wr = 50;
      p_rd = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 150 == 0) begin
            p_wr = $urandom_range(10, 95);
            p_rd = $urandom_range(10, 95);
         end
         wr_en   = ($urandom_range(0, 99) < p_wr);
         rd_en   = ($urandom_range(0, 99) < p_rd);
         wr_data = $urandom;
         rst_n   = ($urandom_range(0, 599) != 0);
`ifdef SYNC_FIFO_ERR_EN
         err_clr = ($urandom_range(0, 9) == 0);
`endif
         cycle();
      end
      rst_n = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
      err_clr = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
